// File: rtl/rtc_uart_reporter.sv
// Snapshots BCD time and streams it as an ASCII report line to a UART over valid/ready.
// Optional "YY-MM-DD " date field is enabled by defining RTC_REPORT_DATE_EN.
module rtc_uart_reporter #(
  parameter int unsigned PREFIX_EN    = 1,
  parameter int unsigned EOL_MODE     = 0,
  parameter int unsigned REPORT_EVERY = 1,
  parameter int unsigned GAP_CYCLES   = 0
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic [7:0] time_sec,
  input  logic [7:0] time_min,
  input  logic [7:0] time_hour,
`ifdef RTC_REPORT_DATE_EN
  input  logic [7:0] time_year,
  input  logic [7:0] time_month,
  input  logic [7:0] time_date,
`endif
  input  logic       force_req,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] drop_cnt
);
  localparam int unsigned PFX_LEN  = (PREFIX_EN != 0) ? 8 : 0;
`ifdef RTC_REPORT_DATE_EN
  localparam int unsigned DATE_LEN = 9;
`else
  localparam int unsigned DATE_LEN = 0;
`endif
  localparam int unsigned TIME_OFS = PFX_LEN + DATE_LEN;
  localparam int unsigned EOL_OFS  = TIME_OFS + 8;
  localparam int unsigned EOL_LEN  = (EOL_MODE == 2) ? 1 : 2;
  localparam int unsigned LINE_LEN = EOL_OFS + EOL_LEN;
  localparam logic [63:0] PREFIX_STR = "Time is ";
  localparam logic [7:0]  EOL0 = (EOL_MODE == 1) ? 8'h0D : 8'h0A;
  localparam logic [7:0]  EOL1 = (EOL_MODE == 1) ? 8'h0A : 8'h0D;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx, idx_nxt;
  logic [15:0] gap_cnt, gap_nxt;
  logic        pending, pending_nxt, drop_inc;
  logic        armed, sec_change, div_trig, trig_q;
  logic [7:0]  sec_prev, div_cnt;
  logic [7:0]  snap_hour, snap_min, snap_sec;
  logic [7:0]  src_hour, src_min, src_sec;
  logic [7:0]  line_c [32];

  function automatic logic [7:0] digit(input logic [3:0] n);
    return (n > 4'd9) ? 8'h3F : 8'h30 + {4'h0, n};
  endfunction

  // Seconds-change detection and report-rate divider
  assign sec_change = armed && (time_sec != sec_prev);
  assign div_trig   = sec_change && (div_cnt == 8'(REPORT_EVERY - 1));

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      armed    <= 1'b0;
      sec_prev <= 8'h00;
      div_cnt  <= 8'h00;
      trig_q   <= 1'b0;
    end else begin
      armed    <= 1'b1;
      sec_prev <= time_sec;
      trig_q   <= div_trig | force_req;
      if (sec_change) div_cnt <= div_trig ? 8'h00 : div_cnt + 8'd1;
    end
  end

  // In LOAD the snapshot is being captured, so read the live fields that cycle
  assign src_hour = (state == LOAD) ? time_hour : snap_hour;
  assign src_min  = (state == LOAD) ? time_min  : snap_min;
  assign src_sec  = (state == LOAD) ? time_sec  : snap_sec;
`ifdef RTC_REPORT_DATE_EN
  logic [7:0] snap_year, snap_month, snap_date;
  logic [7:0] src_year, src_month, src_date;
  assign src_year  = (state == LOAD) ? time_year  : snap_year;
  assign src_month = (state == LOAD) ? time_month : snap_month;
  assign src_date  = (state == LOAD) ? time_date  : snap_date;
`endif

  // Report line assembly
  always_comb begin
    for (int i = 0; i < 32; i++) line_c[i] = 8'h00;
    if (PREFIX_EN != 0)
      for (int i = 0; i < 8; i++) line_c[5'(i)] = PREFIX_STR[63 - 8*i -: 8];
`ifdef RTC_REPORT_DATE_EN
    line_c[5'(PFX_LEN + 0)] = digit(src_year[7:4]);
    line_c[5'(PFX_LEN + 1)] = digit(src_year[3:0]);
    line_c[5'(PFX_LEN + 2)] = 8'h2D;
    line_c[5'(PFX_LEN + 3)] = digit(src_month[7:4]);
    line_c[5'(PFX_LEN + 4)] = digit(src_month[3:0]);
    line_c[5'(PFX_LEN + 5)] = 8'h2D;
    line_c[5'(PFX_LEN + 6)] = digit(src_date[7:4]);
    line_c[5'(PFX_LEN + 7)] = digit(src_date[3:0]);
    line_c[5'(PFX_LEN + 8)] = 8'h20;
`endif
    line_c[5'(TIME_OFS + 0)] = digit(src_hour[7:4]);
    line_c[5'(TIME_OFS + 1)] = digit(src_hour[3:0]);
    line_c[5'(TIME_OFS + 2)] = 8'h3A;
    line_c[5'(TIME_OFS + 3)] = digit(src_min[7:4]);
    line_c[5'(TIME_OFS + 4)] = digit(src_min[3:0]);
    line_c[5'(TIME_OFS + 5)] = 8'h3A;
    line_c[5'(TIME_OFS + 6)] = digit(src_sec[7:4]);
    line_c[5'(TIME_OFS + 7)] = digit(src_sec[3:0]);
    line_c[5'(EOL_OFS)]      = EOL0;
    if (EOL_LEN == 2) line_c[5'(EOL_OFS + 1)] = EOL1;
  end

  // Next-state, byte index, gap timer and pending/drop bookkeeping
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    gap_nxt     = gap_cnt;
    pending_nxt = pending;
    drop_inc    = 1'b0;
    unique case (state)
      IDLE: if (trig_q) state_nxt = LOAD;
      LOAD: begin
        idx_nxt   = 5'd0;
        state_nxt = SEND;
      end
      SEND: if (tx_valid && tx_ready) begin
        idx_nxt = idx + 5'd1;
        if (idx == 5'(LINE_LEN - 1)) state_nxt = DONE;
        else if (GAP_CYCLES != 0) begin
          state_nxt = GAP;
          gap_nxt   = 16'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (gap_cnt == 16'd0) state_nxt = SEND;
        else gap_nxt = gap_cnt - 16'd1;
      end
      DONE: begin
        // A trigger arriving here is kept rather than lost
        state_nxt   = (pending || trig_q) ? LOAD : IDLE;
        pending_nxt = pending && trig_q;
      end
      default: state_nxt = IDLE;
    endcase
    if (trig_q && (state inside {LOAD, SEND, GAP})) begin
      if (pending) drop_inc = 1'b1;
      else pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      idx       <= 5'd0;
      gap_cnt   <= 16'd0;
      pending   <= 1'b0;
      drop_cnt  <= 8'h00;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      snap_hour <= 8'h00;
      snap_min  <= 8'h00;
      snap_sec  <= 8'h00;
`ifdef RTC_REPORT_DATE_EN
      snap_year  <= 8'h00;
      snap_month <= 8'h00;
      snap_date  <= 8'h00;
`endif
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      gap_cnt  <= gap_nxt;
      pending  <= pending_nxt;
      tx_valid <= (state_nxt == SEND);
      busy     <= (state_nxt inside {LOAD, SEND, GAP});
      if (state_nxt == SEND) tx_data <= line_c[idx_nxt];
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (state == LOAD) begin
        snap_hour <= time_hour;
        snap_min  <= time_min;
        snap_sec  <= time_sec;
`ifdef RTC_REPORT_DATE_EN
        snap_year  <= time_year;
        snap_month <= time_month;
        snap_date  <= time_date;
`endif
      end
    end
  end
endmodule
